// File: rtl/inst_fetch_req_way0.sv
// Way-0 fetch-request stage: owns the way-0 PC, issues single-outstanding
// imem requests and forwards each returned instruction as a one-cycle pulse.
module inst_fetch_req_way0 #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] PC_STEP  = 32'd8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ready_i,
  input  logic        jumpFlag_i,
  input  logic [31:0] jumpAddr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] instAddr_o
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT    = 2'd2,
    S_DISCARD = 2'd3
  } state_e;

  state_e            state_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   pc_inc_d;
  logic [XLEN-1:0]   req_addr_q;
  logic [XLEN-1:0]   jump_tgt_d;
  logic              valid_q;
  logic [XLEN-1:0]   inst_q;
  logic [XLEN-1:0]   inst_addr_q;
  logic              grant_d;

  // Request is only raised while the fetch buffer has reserved a slot.
  assign imem_req_o  = (state_q == S_REQ) && ready_i;
  assign imem_addr_o = pc_q;
  assign valid_o     = valid_q;
  assign inst_o      = inst_q;
  assign instAddr_o  = inst_addr_q;

  always_comb begin
    jump_tgt_d = jumpAddr_i & ~XLEN'(3);
    pc_inc_d   = pc_q + PC_STEP;
    grant_d    = imem_req_o && imem_gnt_i;
  end

  // A jump always wins the pc; a response that coincides with a jump, or that
  // belongs to a request granted before the jump, is dropped via DISCARD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      valid_q     <= 1'b0;
      inst_q      <= '0;
      inst_addr_q <= '0;
    end else begin
      valid_q <= 1'b0;
      if (jumpFlag_i) begin
        pc_q <= jump_tgt_d;
      end
      case (state_q)
        S_IDLE: begin
          state_q <= S_REQ;
        end
        S_REQ: begin
          if (grant_d) begin
            req_addr_q <= pc_q;
            state_q    <= jumpFlag_i ? S_DISCARD : S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            state_q <= S_REQ;
            if (!jumpFlag_i) begin
              valid_q     <= 1'b1;
              inst_q      <= imem_rdata_i;
              inst_addr_q <= req_addr_q;
              pc_q        <= pc_inc_d;
            end
          end else if (jumpFlag_i) begin
            state_q <= S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (imem_rvalid_i) begin
            state_q <= S_REQ;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
